// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - requester and memory bus bundle for the instruction memory arbiter
//
// Purpose: groups the fetch port, loader port and memory-side lines of imem_arbiter.
// Ports:   none (bundle only); parameters CPU_WIDTH, ADDR_WIDTH size the buses.
// Modports:
//   slave  - the arbiter: takes requests and mem_rdata, drives readies, responses, mem_*.
//   master - the environment: requesters plus the memory.
interface imem_arbiter_if #(
   parameter int CPU_WIDTH  = 32,
   parameter int ADDR_WIDTH = 10
);
   // fetch port
   logic                  f_req_valid;
   logic                  f_req_ready;
   logic [CPU_WIDTH-1:0]  f_addr;
   logic                  f_rsp_valid;
   logic [CPU_WIDTH-1:0]  f_rsp_inst;
   logic                  f_rsp_err;
   // loader / debug port
   logic                  l_req_valid;
   logic                  l_req_ready;
   logic                  l_we;
   logic [CPU_WIDTH-1:0]  l_addr;
   logic [CPU_WIDTH-1:0]  l_wdata;
   logic                  l_lock;
   logic                  l_rsp_valid;
   logic [CPU_WIDTH-1:0]  l_rsp_data;
   logic                  l_rsp_err;
   // memory side
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [CPU_WIDTH-1:0]  mem_wdata;
   logic [CPU_WIDTH-1:0]  mem_rdata;

   modport slave (
      input  f_req_valid, f_addr,
      output f_req_ready, f_rsp_valid, f_rsp_inst, f_rsp_err,
      input  l_req_valid, l_we, l_addr, l_wdata, l_lock,
      output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output f_req_valid, f_addr,
      input  f_req_ready, f_rsp_valid, f_rsp_inst, f_rsp_err,
      output l_req_valid, l_we, l_addr, l_wdata, l_lock,
      input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory arbiter for fetch and loader
//
// Purpose: grants one word access per cycle to either the core fetch stage or the
//          program loader, drives the memory lines combinationally and registers
//          the response one cycle after grant. Fetch has priority; the loader is
//          forced ahead after STARVE_LIMIT denied cycles; l_lock shuts fetch out.
// Ports:
//   clk   - clock, all state on rising edge
//   rstn  - asynchronous active-low reset
//   bus   - imem_arbiter_if.slave: fetch req/rsp, loader req/rsp, mem_addr/we/wdata/rdata
module imem_arbiter #(
   parameter int CPU_WIDTH    = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int STARVE_LIMIT = 4
) (
   input logic          clk,
   input logic          rstn,
   imem_arbiter_if.slave bus
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]           starve_cnt;
   logic                 gnt_f;
   logic                 gnt_l;
   logic [CPU_WIDTH-1:0] sel_addr;
   logic                 addr_err;

   // Arbitration: lock excludes fetch entirely; otherwise fetch wins a tie
   // unless the loader has been denied for STARVE_LIMIT cycles in a row.
   always_comb begin
      gnt_f = 1'b0;
      gnt_l = 1'b0;
      if (bus.l_lock) begin
         gnt_l = bus.l_req_valid;
      end else if (bus.f_req_valid && bus.l_req_valid) begin
         gnt_l = (starve_cnt == LIMIT);
         gnt_f = !gnt_l;
      end else begin
         gnt_f = bus.f_req_valid;
         gnt_l = bus.l_req_valid;
      end
   end

   assign bus.f_req_ready = gnt_f;
   assign bus.l_req_ready = gnt_l;

   // Error covers misalignment and any address bit above the memory's word range.
   always_comb begin
      sel_addr = gnt_l ? bus.l_addr : bus.f_addr;
      addr_err = (sel_addr[1:0] != 2'b00) ||
                 (sel_addr[CPU_WIDTH-1:ADDR_WIDTH+2] != '0);
   end

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = bus.l_wdata;
      if (gnt_f || gnt_l) begin
         bus.mem_addr = sel_addr[ADDR_WIDTH+1:2];
      end
      bus.mem_we = gnt_l && bus.l_we && !addr_err;
   end

   // Responses cannot stall: each grant produces exactly one pulse next cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.f_rsp_valid <= 1'b0;
         bus.f_rsp_inst  <= '0;
         bus.f_rsp_err   <= 1'b0;
         bus.l_rsp_valid <= 1'b0;
         bus.l_rsp_data  <= '0;
         bus.l_rsp_err   <= 1'b0;
      end else begin
         bus.f_rsp_valid <= gnt_f;
         bus.f_rsp_inst  <= (gnt_f && !addr_err) ? bus.mem_rdata : '0;
         bus.f_rsp_err   <= gnt_f && addr_err;
         bus.l_rsp_valid <= gnt_l;
         bus.l_rsp_data  <= (gnt_l && !addr_err && !bus.l_we) ? bus.mem_rdata : '0;
         bus.l_rsp_err   <= gnt_l && addr_err;
      end
   end

   // Counts consecutive denied loader cycles; saturates so the forced grant
   // condition stays true until the loader is actually served.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         starve_cnt <= 4'd0;
      end else if (bus.l_req_valid && !gnt_l) begin
         if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end else begin
         starve_cnt <= 4'd0;
      end
   end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard testbench for imem_arbiter
module tb_imem_arbiter;
   localparam int CW    = 32;
   localparam int AW    = 10;
   localparam int LIMIT = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   rsp_t f_q[$];
   rsp_t l_q[$];

   logic [31:0] mem    [0:1023];
   logic [31:0] shadow [0:1023];

   int          m_starve = 0;
   logic        e_gf, e_gl, e_err, e_we;
   logic [31:0] e_sel;
   logic [9:0]  e_idx;
   rsp_t        r;

   imem_arbiter_if #(.CPU_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

   imem_arbiter #(.CPU_WIDTH(CW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // memory model: combinational read, write on rising edge
   assign bus.mem_rdata = mem[bus.mem_addr];
   initial begin
      forever begin
         @(posedge clk);
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // request-side model: predict grant, memory drive and response; push to scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            m_starve = 0;
         end else begin
            if (bus.l_lock) begin
               e_gl = bus.l_req_valid; e_gf = 1'b0;
            end else if (bus.f_req_valid && bus.l_req_valid) begin
               e_gl = (m_starve == LIMIT); e_gf = !e_gl;
            end else begin
               e_gf = bus.f_req_valid; e_gl = bus.l_req_valid;
            end
            e_sel = e_gl ? bus.l_addr : bus.f_addr;
            e_err = (e_sel[1:0] != 2'b00) || (e_sel[31:12] != 20'd0);
            e_idx = (e_gf || e_gl) ? e_sel[11:2] : 10'd0;
            e_we  = e_gl && bus.l_we && !e_err;
            check("f_req_ready", 32'(bus.f_req_ready), 32'(e_gf));
            check("l_req_ready", 32'(bus.l_req_ready), 32'(e_gl));
            check("mem_addr", 32'(bus.mem_addr), 32'(e_idx));
            check("mem_we", 32'(bus.mem_we), 32'(e_we));
            check("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
            if (e_we) check("mem_wdata", bus.mem_wdata, bus.l_wdata);
            if (e_gf) f_q.push_back('{data: e_err ? 32'd0 : shadow[e_idx], err: e_err});
            if (e_gl) l_q.push_back('{data: (e_err || bus.l_we) ? 32'd0 : shadow[e_idx], err: e_err});
            if (e_we) shadow[e_idx] = bus.l_wdata;
            if (bus.l_req_valid && !e_gl) m_starve = (m_starve == LIMIT) ? LIMIT : m_starve + 1;
            else m_starve = 0;
         end
      end
   end

   // response-side: pop and compare each pulse; nothing may remain pending
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rstn) begin
            check("rst_f_rsp_valid", 32'(bus.f_rsp_valid), 32'd0);
            check("rst_l_rsp_valid", 32'(bus.l_rsp_valid), 32'd0);
            check("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
            f_q.delete();
            l_q.delete();
         end else begin
            if (bus.f_rsp_valid) begin
               if (f_q.size() == 0) check("f_rsp_unexpected", 32'd1, 32'd0);
               else begin
                  r = f_q.pop_front();
                  check("f_rsp_inst", bus.f_rsp_inst, r.data);
                  check("f_rsp_err", 32'(bus.f_rsp_err), 32'(r.err));
               end
            end
            if (bus.l_rsp_valid) begin
               if (l_q.size() == 0) check("l_rsp_unexpected", 32'd1, 32'd0);
               else begin
                  r = l_q.pop_front();
                  check("l_rsp_data", bus.l_rsp_data, r.data);
                  check("l_rsp_err", 32'(bus.l_rsp_err), 32'(r.err));
               end
            end
            check("f_rsp_missing", 32'(f_q.size()), 32'd0);
            check("l_rsp_missing", 32'(l_q.size()), 32'd0);
            f_q.delete();
            l_q.delete();
         end
      end
   end

   task automatic set_in(input logic fv, input logic [31:0] fa, input logic lv, input logic we,
                         input logic [31:0] la, input logic [31:0] wd, input logic lock);
      bus.f_req_valid = fv;
      bus.f_addr      = fa;
      bus.l_req_valid = lv;
      bus.l_we        = we;
      bus.l_addr      = la;
      bus.l_wdata     = wd;
      bus.l_lock      = lock;
   endtask

   task automatic drive(input logic fv, input logic [31:0] fa, input logic lv, input logic we,
                        input logic [31:0] la, input logic [31:0] wd, input logic lock);
      set_in(fv, fa, lv, we, la, wd, lock);
      @(posedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 32'd0;
         shadow[i] = 32'd0;
      end
      mem[0] = 32'h0000_0013; shadow[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093; shadow[1] = 32'h0010_0093;
      mem[2] = 32'h0020_0113; shadow[2] = 32'h0020_0113;
      mem[5] = 32'hA5A5_0005; shadow[5] = 32'hA5A5_0005;
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rstn = 1'b1;
      check("post_rst_f_rsp_valid", 32'(bus.f_rsp_valid), 32'd0);
      check("post_rst_l_rsp_valid", 32'(bus.l_rsp_valid), 32'd0);
      check("post_rst_f_rsp_inst", bus.f_rsp_inst, 32'd0);

      // fetch-only stream
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // both valid: fetch x4, loader on the 5th, repeating
      for (int i = 0; i < 12; i++) drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h14, 32'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // locked download: write then read back the same word
      drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1);
      drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'd0, 1'b1);
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h40, 32'd0, 1'b1);
      check("mem_0x40", mem[16], 32'hDEAD_BEEF);

      // errors: misaligned fetch, out-of-range loader write, then confirm word 0 untouched
      drive(1'b1, 32'h2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'h1234_5678, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      check("mem_word0_kept", mem[0], 32'h0000_0013);

      // reset in the cycle after a granted fetch drops the response
      set_in(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'd0, 1'b0);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      rstn = 1'b1;
      drive(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // mixed random traffic, including lock toggles and occasional bad addresses
      for (int i = 0; i < 60; i++) begin
         logic [31:0] fa, la;
         fa = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         la = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         if ($urandom_range(0, 9) == 0) fa[0] = 1'b1;
         if ($urandom_range(0, 9) == 0) la[13] = 1'b1;
         drive(1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               la, $urandom, ($urandom_range(0, 4) == 0));
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port instruction memory between two requesters: the core fetch stage and the program loader/debug port.
Arbitrates one word access per cycle and drives the memory address, write-enable and write-data lines.
Captures the memory's combinational read data into registered responses one cycle after grant.
Fetch has priority, with a starvation limit for the loader and a lock input that holds the core off during program download.

Parameters:
CPU_WIDTH, 32, data/address width of both requester ports
ADDR_WIDTH, 10, word-index width of the instruction memory (depth = 2**ADDR_WIDTH words)
STARVE_LIMIT, 4, consecutive denied loader cycles before the loader is forced ahead of fetch (range 1..15)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
f_req_valid  input  1  fetch request present
f_req_ready  output  1  fetch request granted this cycle (combinational)
f_addr  input  CPU_WIDTH  fetch byte address
f_rsp_valid  output  1  fetch response, one-cycle pulse
f_rsp_inst  output  CPU_WIDTH  fetched instruction
f_rsp_err  output  1  fetch address misaligned or out of range
l_req_valid  input  1  loader request present
l_req_ready  output  1  loader request granted this cycle (combinational)
l_we  input  1  1 = write, 0 = read
l_addr  input  CPU_WIDTH  loader byte address
l_wdata  input  CPU_WIDTH  loader write data
l_lock  input  1  level; while 1, fetch is never granted
l_rsp_valid  output  1  loader response, one-cycle pulse
l_rsp_data  output  CPU_WIDTH  read data (0 for writes)
l_rsp_err  output  1  loader address misaligned or out of range
mem_addr  output  ADDR_WIDTH  word index to memory (combinational)
mem_we  output  1  memory write enable (combinational)
mem_wdata  output  CPU_WIDTH  memory write data (combinational)
mem_rdata  input  CPU_WIDTH  combinational read data from memory at mem_addr

Behaviour:
- Reset (rstn=0, async):
  - All registered outputs clear to 0: f_rsp_*, l_rsp_*.
  - starve_cnt clears to 0.
  - An in-flight response is dropped; no response pulse follows reset release.
- Grant, evaluated combinationally each cycle, at most one grant:
  - l_lock=1: the loader is granted if l_req_valid; fetch is never granted.
  - Else, both valid: the loader wins if starve_cnt==STARVE_LIMIT; otherwise fetch wins.
  - Else: the single valid requester is granted.
  - No request: no grant.
- Ready and transfer:
  - *_req_ready equals the grant.
  - A transfer occurs when valid&&ready.
  - Requesters hold address and data stable while valid&&!ready.
- starve_cnt (4-bit register):
  - Increments, saturating at STARVE_LIMIT, when l_req_valid&&!l_req_ready.
  - Clears to 0 on loader grant or when l_req_valid=0.
- Address check (per granted request): error if addr[1:0]!=0 or addr[CPU_WIDTH-1:ADDR_WIDTH+2]!=0.
- Memory drive:
  - mem_addr = granted addr[ADDR_WIDTH+1:2].
  - mem_wdata = l_wdata.
  - mem_we = loader grant && l_we && !error.
  - With no grant: mem_addr=0, mem_we=0.
  - An erroring access never writes.
- Response timing (latency 1): on the rising edge ending a granted cycle, the granted side's *_rsp_valid is set to 1 for exactly one cycle.
- Response data:
  - Fetch, or loader read: data = mem_rdata sampled at that edge.
  - Loader write: data = 0.
  - Error: data = 0, *_rsp_err = 1.
  - Non-granted side: *_rsp_valid = 0.
- Responses cannot be back-pressured. Back-to-back grants give back-to-back pulses, one per cycle.
- Write-then-read of the same word on consecutive cycles returns the new data; the memory is written at the first edge.
- l_lock asserted or deasserted mid-stream takes effect in the same cycle's arbitration.
- A pending fetch response already registered is still delivered.

Test Plan:
- Reset release, then fetch-only stream at addrs 0x0,0x4,0x8 with memory preloaded 0x00000013,0x00100093,0x00200113 -> f_req_ready=1 each cycle; f_rsp_inst equals those words one cycle later; l_rsp_valid=0 throughout.
- Both valid continuously, STARVE_LIMIT=4 -> fetch granted 4 cycles, loader on 5th, then repeats; starve_cnt saturates at 4, clears on grant.
- l_lock=1, loader writes 0xDEADBEEF to 0x40, then reads 0x40 next cycle -> f_req_ready=0 throughout; write response data 0; read response 0xDEADBEEF.
- Misaligned fetch 0x2 and loader write to 0x1000 (ADDR_WIDTH=10) -> rsp_err=1, data 0, mem_we=0, memory unchanged.
- Assert rstn=0 in the cycle after a granted fetch -> f_rsp_valid stays 0, starve_cnt=0; first post-reset request behaves normally.
